// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state type, byte-count constants and byte-lane helper for the AES byte-stream controller
package aes_ctrl_pkg;
  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, DRAIN} state_t;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] BLOCK_BYTES = 5'd16;
  localparam logic [CNT_W-1:0] LAST_BYTE = 5'd15;
  function automatic logic [7:0] head_byte(input logic [127:0] d, input bit msb);
    return msb ? d[127:120] : d[7:0];
  endfunction
endpackage

// File: rtl/aes_byte_shreg.sv
// aes_byte_shreg: 128-bit byte shift register with parallel load; MSB_FIRST picks which end the first byte occupies
module aes_byte_shreg #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] load_data,
  input  logic         shift,
  input  logic [7:0]   in_byte,
  output logic [127:0] data
);
  // load wins over shift; a shift drops the head byte and enters in_byte at the far end
  always_ff @(posedge clk) begin
    if (!reset) data <= '0;
    else if (load) data <= load_data;
    else if (shift) data <= MSB_FIRST ? {data[119:0], in_byte} : {in_byte, data[127:8]};
  end
endmodule

// File: rtl/aes_byte_stream_ctrl.sv
// aes_byte_stream_ctrl: byte-stream front end for the AES-128 core; define AES_CTRL_TIMEOUT_EN for the WAIT timeout and err flag
module aes_byte_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_is_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out,
  output logic         busy,
  output logic         err
);
  state_t state, state_nx;
  logic [CNT_W-1:0] key_cnt, pt_cnt, out_cnt;
  logic key_ok, go, key_acc, pt_acc, cap, out_acc, last_out, tout;
  logic [127:0] out_q;
  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 16..65535");
  end
  assign go = state == COLLECT && pt_cnt == BLOCK_BYTES && key_ok;
  assign key_acc = in_valid && in_ready && in_is_key;
  assign pt_acc = in_valid && in_ready && !in_is_key;
  assign cap = state == WAIT && aes_done;
  assign out_acc = state == DRAIN && out_ready;
  assign last_out = out_acc && out_cnt == LAST_BYTE;
  assign out_data = head_byte(out_q, MSB_FIRST);
  aes_byte_shreg #(.MSB_FIRST(MSB_FIRST)) u_key (
    .clk(clk), .reset(reset), .load(1'b0), .load_data('0),
    .shift(key_acc), .in_byte(in_data), .data(aes_key)
  );
  aes_byte_shreg #(.MSB_FIRST(MSB_FIRST)) u_text (
    .clk(clk), .reset(reset), .load(1'b0), .load_data('0),
    .shift(pt_acc), .in_byte(in_data), .data(aes_text_in)
  );
  aes_byte_shreg #(.MSB_FIRST(MSB_FIRST)) u_out (
    .clk(clk), .reset(reset), .load(cap), .load_data(aes_text_out),
    .shift(out_acc), .in_byte(8'h00), .data(out_q)
  );
  // next state and handshake outputs; inputs close as soon as a complete block is ready to launch
  always_comb begin
    state_nx = go ? LAUNCH : state == LAUNCH ? WAIT : cap ? DRAIN : (last_out || tout) ? COLLECT : state;
    in_ready = state == COLLECT && !go && (in_is_key || pt_cnt < BLOCK_BYTES);
    aes_ld = state == LAUNCH;
    out_valid = state == DRAIN;
    busy = state != COLLECT;
  end
  // state register and byte counters; a key byte arriving with key_ok set starts a fresh key
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= COLLECT;
      key_cnt <= '0;
      pt_cnt <= '0;
      out_cnt <= '0;
      key_ok <= 1'b0;
    end else begin
      state <= state_nx;
      if (key_acc) begin
        key_ok <= !key_ok && key_cnt == LAST_BYTE;
        key_cnt <= key_ok ? CNT_W'(1) : key_cnt == LAST_BYTE ? '0 : key_cnt + 1'b1;
      end
      pt_cnt <= (last_out || tout) ? '0 : pt_acc ? pt_cnt + 1'b1 : pt_cnt;
      out_cnt <= cap ? '0 : out_acc ? out_cnt + 1'b1 : out_cnt;
    end
  end
`ifdef AES_CTRL_TIMEOUT_EN
  logic [15:0] tcnt;
  logic err_q;
  assign tout = state == WAIT && !aes_done && tcnt == 16'(TIMEOUT_CYCLES - 1);
  assign err = err_q;
  // WAIT cycle counter and sticky timeout flag; a done on the final cycle still captures
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
      err_q <= err_q || tout;
    end
  end
`else
  assign tout = 1'b0;
  assign err = 1'b0;
`endif
endmodule
